led_frame_tx: RTL and testbench

Downstream consumer of the per-zone colour accumulators: walks the zone results in address order and serialises them onto the single-wire WS2812-style LED data line. On a `start` pulse it sends one complete frame of `N_LEDS` 24-bit GRB words, MSB first, with no gaps between LEDs, then holds the line low for the latch/reset interval. One instance drives one LED strip. Zone results are read through a registered address/data port, so the accumulator bank is muxed outside this block.

---
 rtl/led_frame_tx.sv | 168 ++++++++++++++++
 tb/tb_led_frame_tx.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_tx.sv
`timescale 1ns / 1ps
// led_frame_tx: walks N_LEDS zone results in address order and serialises
// them onto a WS2812-style single-wire line, followed by a latch interval.
//
// state | meaning
// IDLE  | line low, waiting for start
// FETCH | capture LED 0 into the shift register, point address at LED 1
// SEND  | drive bit periods back to back, prefetch the next LED word
// LATCH | line low for RESET_CYCLES, then done pulse
module led_frame_tx #(
  parameter int N_LEDS       = 60,
  parameter int T_BIT        = 63,
  parameter int T0H          = 20,
  parameter int T1H          = 40,
  parameter int RESET_CYCLES = 14000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [6:0]  led_addr,
  input  logic [23:0] led_data,
  output logic        dout,
  output logic        busy,
  output logic        done
);

  localparam int PH_W  = (T_BIT > 1) ? $clog2(T_BIT) : 1;
  localparam int LAT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(T_BIT - 1);
  localparam logic [PH_W-1:0]  T0H_C    = PH_W'(T0H);
  localparam logic [PH_W-1:0]  T1H_C    = PH_W'(T1H);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RESET_CYCLES - 1);
  localparam logic [6:0]       LED_LAST = 7'(N_LEDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [4:0]        bit_q, bit_d;
  logic [6:0]        led_q, led_d;
  logic [6:0]        addr_q, addr_d;
  logic [23:0]       shift_q, shift_d;
  logic [23:0]       nbuf_q, nbuf_d;
  logic              pf_q, pf_d;
  logic              dout_q, dout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state, counters, prefetch and line level for the coming cycle.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    lat_d   = lat_q;
    bit_d   = bit_q;
    led_d   = led_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    nbuf_d  = nbuf_q;
    pf_d    = pf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          addr_d  = 7'd0;
          busy_d  = 1'b1;
        end
      end
      FETCH: begin
        shift_d = led_data;
        bit_d   = 5'd23;
        led_d   = 7'd0;
        phase_d = '0;
        // A single-LED strip has nothing to prefetch; the address stays at 0.
        if (LED_LAST != 7'd0) begin
          addr_d = 7'd1;
          pf_d   = 1'b1;
        end else begin
          addr_d = 7'd0;
          pf_d   = 1'b0;
        end
        state_d = SEND;
      end
      SEND: begin
        // Read data is valid exactly one cycle after the address moved.
        if (pf_q) begin
          nbuf_d = led_data;
          pf_d   = 1'b0;
        end
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (bit_q != 5'd0) begin
            shift_d = {shift_q[22:0], 1'b0};
            bit_d   = bit_q - 5'd1;
          end else if (led_q != LED_LAST) begin
            shift_d = nbuf_q;
            led_d   = led_q + 7'd1;
            bit_d   = 5'd23;
            if (addr_q != LED_LAST) begin
              addr_d = addr_q + 7'd1;
              pf_d   = 1'b1;
            end
          end else begin
            state_d = LATCH;
            lat_d   = LAT_LAST;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      LATCH: begin
        if (lat_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is derived from the values being loaded so it lines up
    // with the state it belongs to.
    dout_d = (state_d == SEND) && (phase_d < (shift_d[23] ? T1H_C : T0H_C));
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      lat_q   <= '0;
      bit_q   <= 5'd0;
      led_q   <= 7'd0;
      addr_q  <= 7'd0;
      shift_q <= 24'd0;
      nbuf_q  <= 24'd0;
      pf_q    <= 1'b0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      lat_q   <= lat_d;
      bit_q   <= bit_d;
      led_q   <= led_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      nbuf_q  <= nbuf_d;
      pf_q    <= pf_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign led_addr = addr_q;
  assign dout     = dout_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_led_frame_tx.sv
`timescale 1ns / 1ps
// Bench for led_frame_tx: a two-LED instance and a single-LED instance,
// checked every cycle against a frame-timing model plus literal timing pins.
module tb_led_frame_tx;

  localparam int T_BIT = 10;
  localparam int T0H   = 3;
  localparam int T1H   = 6;
  localparam int RST_C = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [2];
  logic        start_v [2];
  logic [6:0]  addr_v  [2];
  logic [23:0] data_v  [2];
  logic        dout_v  [2];
  logic        busy_v  [2];
  logic        done_v  [2];

  led_frame_tx #(.N_LEDS(2), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .RESET_CYCLES(RST_C)) u_dut2 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .led_addr(addr_v[0]),
    .led_data(data_v[0]), .dout(dout_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  led_frame_tx #(.N_LEDS(1), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .RESET_CYCLES(RST_C)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .led_addr(addr_v[1]),
    .led_data(data_v[1]), .dout(dout_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit check_en = 0;
  int n_leds [2] = '{2, 1};

  // model state
  bit          in_frame  [2];
  int          s_edge    [2];
  int          addr_hold [2];
  logic [23:0] fdata     [2][2];

  // stimulus data for the two-LED instance
  logic [23:0] mem [2];
  bit          mode = 0;
  logic [6:0]  last_addr = 7'd0;

  // monitors
  int hi_len [2];
  int lo_len [2];
  int last_lo [2];
  int done_cnt [2];
  int max_addr [2];
  int runs0 [$];
  int runs1 [$];

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", name, d, cyc, act, exp);
    end
  endtask

  // Zone source: mode 0 is a plain lookup; mode 1 returns the real word only
  // in the cycle right after the address moved, garbage otherwise.
  always @(posedge clk) begin
    #1;
    if (mode) begin
      if (addr_v[0] != last_addr) data_v[0] = 24'hA5A5A5;
      else data_v[0] = 24'($urandom) ^ 24'h0F0F0F;
    end else begin
      data_v[0] = mem[addr_v[0][0]];
    end
    last_addr = addr_v[0];
  end

  // Model: decides frame acceptance from start/rst, per edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      int  last;
      bit  idle;
      last = n_leds[d] * 24 * T_BIT + RST_C + 1;
      idle = !in_frame[d] || ((cyc - 1 - s_edge[d]) == last);
      if (rst_v[d]) begin
        in_frame[d]  = 0;
        addr_hold[d] = 0;
      end else if (idle && start_v[d]) begin
        in_frame[d] = 1;
        s_edge[d]   = cyc;
        if (d == 1) begin
          fdata[1][0] = 24'h800001;
          fdata[1][1] = 24'h800001;
        end else begin
          fdata[0][0] = mode ? 24'hA5A5A5 : mem[0];
          fdata[0][1] = mode ? 24'hA5A5A5 : mem[1];
        end
      end else if (in_frame[d] && (cyc - s_edge[d]) > last) begin
        in_frame[d]  = 0;
        addr_hold[d] = n_leds[d] - 1;
      end
    end
  end

  // Expected outputs r cycles after the start-sampling edge.
  function automatic void model_out(input int d, input int r, output bit e_dout,
                                    output bit e_busy, output bit e_done, output int e_addr);
    int n, nt, i, k, bp, ph;
    bit b;
    n  = n_leds[d];
    nt = n * 24 * T_BIT;
    e_dout = 0; e_busy = 0; e_done = 0; e_addr = addr_hold[d];
    if (!in_frame[d]) return;
    if (r == 0) begin
      e_busy = 1; e_addr = 0;
    end else if (r <= nt) begin
      i  = r - 1;
      k  = i / (24 * T_BIT);
      bp = (i % (24 * T_BIT)) / T_BIT;
      ph = i % T_BIT;
      b  = fdata[d][k][23 - bp];
      e_dout = (ph < (b ? T1H : T0H));
      e_busy = 1;
      e_addr = (k + 1 < n) ? k + 1 : n - 1;
    end else if (r <= nt + RST_C) begin
      e_busy = 1; e_addr = n - 1;
    end else begin
      e_done = 1; e_addr = n - 1;
    end
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (check_en) begin
      for (int d = 0; d < 2; d++) begin
        bit e_dout, e_busy, e_done;
        int e_addr;
        model_out(d, cyc - s_edge[d], e_dout, e_busy, e_done, e_addr);
        chk("dout", d, 64'(dout_v[d]), 64'(e_dout));
        chk("busy", d, 64'(busy_v[d]), 64'(e_busy));
        chk("done", d, 64'(done_v[d]), 64'(e_done));
        chk("led_addr", d, 64'(addr_v[d]), 64'(e_addr));
      end
    end
  end

  // Pulse-width, done and address monitors.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (dout_v[d]) begin
        if (hi_len[d] == 0) last_lo[d] = lo_len[d];
        hi_len[d]++;
        lo_len[d] = 0;
      end else begin
        if (hi_len[d] > 0) begin
          if (d == 0) runs0.push_back(hi_len[d]);
          else runs1.push_back(hi_len[d]);
        end
        hi_len[d] = 0;
        lo_len[d]++;
      end
      if (done_v[d]) done_cnt[d]++;
      if (int'(addr_v[d]) > max_addr[d]) max_addr[d] = int'(addr_v[d]);
    end
  end

  task automatic wait_cyc(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic start_frame(input int d, output int s);
    @(negedge clk);
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    s = cyc;
  endtask

  task automatic pulse_at(input int d, input int e);
    wait_cyc(e - 1);
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int max, output int c);
    c = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done_v[d]) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout dut%0d: no done within %0d cycles", d, max);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, cd, cd2, cr;
    logic [47:0] got;
    int exp_run;

    mem[0] = 24'hFF0000;
    mem[1] = 24'h00000F;
    data_v[0] = mem[0];
    data_v[1] = 24'h800001;
    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b1; start_v[d] = 1'b0;
      hi_len[d] = 0; lo_len[d] = 0; last_lo[d] = 0; done_cnt[d] = 0; max_addr[d] = 0;
      in_frame[d] = 0; s_edge[d] = 0; addr_hold[d] = 0;
    end
    repeat (3) @(negedge clk);
    check_en = 1;
    chk("reset_dout", 0, 64'(dout_v[0]), 64'd0);
    chk("reset_busy", 0, 64'(busy_v[0]), 64'd0);
    chk("reset_addr", 0, 64'(addr_v[0]), 64'd0);
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
    repeat (3) @(negedge clk);

    // Basic frame
    runs0.delete();
    start_frame(0, s);
    wait_done(0, 1000, cd);
    chk("basic_done_lat", 0, 64'(cd + 1 - s), 64'd502);
    #1;
    chk("basic_runs", 0, 64'(runs0.size()), 64'd48);
    for (int i = 0; i < runs0.size() && i < 48; i++) begin
      exp_run = (i < 8 || i >= 44) ? T1H : T0H;
      chk("basic_run_w", 0, 64'(runs0[i]), 64'(exp_run));
    end

    // Address / read latency
    repeat (5) @(negedge clk);
    mode = 1;
    runs0.delete();
    max_addr[0] = 0;
    start_frame(0, s);
    wait_done(0, 1000, cd);
    #1;
    got = '0;
    foreach (runs0[i]) got = {got[46:0], (runs0[i] == T1H)};
    chk("addr_runs", 0, 64'(runs0.size()), 64'd48);
    chk("addr_bits", 0, 64'(got), 64'hA5A5A5A5A5A5);
    chk("addr_max", 0, 64'(max_addr[0]), 64'd1);
    @(negedge clk);
    mode = 0;

    // Busy rejection
    repeat (5) @(negedge clk);
    done_cnt[0] = 0;
    start_frame(0, s);
    pulse_at(0, s + 50);
    pulse_at(0, s + 300);
    wait_done(0, 1000, cd);
    chk("rej_done_lat", 0, 64'(cd + 1 - s), 64'd502);
    repeat (40) @(negedge clk);
    #1;
    chk("rej_done_cnt", 0, 64'(done_cnt[0]), 64'd1);

    // Back-to-back with start held
    @(negedge clk);
    start_v[0] = 1'b1;
    s = cyc + 1;
    wait_done(0, 1000, cd);
    chk("b2b_lat1", 0, 64'(cd + 1 - s), 64'd502);
    cr = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dout_v[0]) begin cr = cyc; break; end
    end
    #1;
    chk("b2b_gap", 0, 64'(cr - cd), 64'd2);
    // 4 low cycles closing the final '1' bit, 20 latch, done cycle, fetch
    chk("b2b_low", 0, 64'(last_lo[0]), 64'd26);
    wait_done(0, 1000, cd2);
    start_v[0] = 1'b0;
    chk("b2b_lat2", 0, 64'(cd2 - cd), 64'd502);

    // Reset mid-frame
    repeat (5) @(negedge clk);
    done_cnt[0] = 0;
    start_frame(0, s);
    wait_cyc(s + 99);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    chk("midrst_dout", 0, 64'(dout_v[0]), 64'd0);
    chk("midrst_busy", 0, 64'(busy_v[0]), 64'd0);
    chk("midrst_addr", 0, 64'(addr_v[0]), 64'd0);
    repeat (600) @(negedge clk);
    #1;
    chk("midrst_no_done", 0, 64'(done_cnt[0]), 64'd0);
    mem[0] = 24'h3C0F81;
    mem[1] = 24'hC3F07E;
    runs0.delete();
    start_frame(0, s);
    wait_done(0, 1000, cd);
    chk("midrst_relat", 0, 64'(cd + 1 - s), 64'd502);
    #1;
    got = '0;
    foreach (runs0[i]) got = {got[46:0], (runs0[i] == T1H)};
    chk("midrst_bits", 0, 64'(got), 64'h3C0F81C3F07E);

    // Single LED
    repeat (5) @(negedge clk);
    runs1.delete();
    max_addr[1] = 0;
    start_frame(1, s);
    wait_done(1, 600, cd);
    chk("single_lat", 1, 64'(cd + 1 - s), 64'd262);
    #1;
    chk("single_runs", 1, 64'(runs1.size()), 64'd24);
    for (int i = 0; i < runs1.size() && i < 24; i++) begin
      exp_run = (i == 0 || i == 23) ? T1H : T0H;
      chk("single_run_w", 1, 64'(runs1[i]), 64'(exp_run));
    end
    chk("single_addr", 1, 64'(max_addr[1]), 64'd0);

    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
